// File: rtl/md_if.sv
// Handshake/operand bundle between the E-stage controller and the multiply/divide sequencer.
interface md_if;
    logic        Start;
    logic [2:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Flush;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (output Start, MDOp, A, B, Flush, input Busy, HI, LO);
    modport slave  (input Start, MDOp, A, B, Flush, output Busy, HI, LO);
endinterface

// File: rtl/md_sequencer.sv
// Multiply/divide sequencer: latches operands on launch, counts fixed latency,
// then commits the result into the HI/LO registers it owns.
module md_sequencer #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic clk,
    input  logic reset,
    md_if.slave  bus
);
    localparam int MAXC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {IDLE, RUN} state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           busy_q, busy_d;
    logic [31:0]    hi_q, hi_d, lo_q, lo_d;
    logic [31:0]    a_q, a_d, b_q, b_d;
    logic [1:0]     op_q, op_d;

    // Result datapath works only from the latched operands.
    logic [63:0] prod_s, prod_u;
    logic [31:0] abs_a, abs_b, uq, ur, res_hi, res_lo;
    logic        a_neg, b_neg, sgn;

    always_comb begin
        sgn    = ~op_q[0];
        a_neg  = sgn & a_q[31];
        b_neg  = sgn & b_q[31];
        abs_a  = a_neg ? (~a_q + 32'd1) : a_q;
        abs_b  = b_neg ? (~b_q + 32'd1) : b_q;
        uq     = (b_q == 32'd0) ? 32'd0 : abs_a / abs_b;
        ur     = (b_q == 32'd0) ? 32'd0 : abs_a % abs_b;
        prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
        prod_u = {32'd0, a_q} * {32'd0, b_q};
        if (!op_q[1]) begin
            {res_hi, res_lo} = sgn ? prod_s : prod_u;
        end else if (b_q == 32'd0) begin
            res_hi = a_q;
            res_lo = 32'hFFFF_FFFF;
        end else begin
            // Sign-magnitude division: 0x80000000 / -1 falls out as 0x80000000 rem 0.
            res_lo = (a_neg ^ b_neg) ? (~uq + 32'd1) : uq;
            res_hi = a_neg ? (~ur + 32'd1) : ur;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        case (state_q)
            IDLE: begin
                if (!bus.Flush) begin
                    if (bus.Start && !bus.MDOp[2]) begin
                        a_d     = bus.A;
                        b_d     = bus.B;
                        op_d    = bus.MDOp[1:0];
                        cnt_d   = bus.MDOp[1] ? CW'(DIV_CYC - 1) : CW'(MULT_CYC - 1);
                        busy_d  = 1'b1;
                        state_d = RUN;
                    end else if (!bus.Start && bus.MDOp == 3'b100) begin
                        hi_d = bus.A;
                    end else if (!bus.Start && bus.MDOp == 3'b101) begin
                        lo_d = bus.A;
                    end
                end
            end
            RUN: begin
                // Flush does not abort an op in flight; Start/mthi/mtlo are ignored here.
                if (cnt_q == '0) begin
                    hi_d    = res_hi;
                    lo_d    = res_lo;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
        end
    end

    assign bus.Busy = busy_q;
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;
endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer: latency, arithmetic corner cases, flush and mthi/mtlo.
module tb_md_sequencer;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    md_if mif ();

    md_sequencer #(.MULT_CYC(5), .DIV_CYC(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (mif.slave)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mif.Start = 1'b0;
        mif.MDOp  = 3'b111;
        mif.A     = '0;
        mif.B     = '0;
        mif.Flush = 1'b0;
    endtask

    task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        mif.Start = 1'b1;
        mif.MDOp  = op;
        mif.A     = a;
        mif.B     = b;
        tick();
        idle_inputs();
    endtask

    // Counts cycles with Busy=1 starting from the cycle after launch; bounded.
    task automatic count_busy(output int n);
        n = 0;
        while (mif.Busy === 1'b1 && n < 50) begin
            n++;
            tick();
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int ncyc,
                          input logic [31:0] ehi, input logic [31:0] elo);
        int n;
        launch(op, a, b);
        count_busy(n);
        total++;
        if (n != ncyc) begin
            bad++;
            $display("FAIL %s busy_cycles got=%0d exp=%0d", name, n, ncyc);
        end
        total++;
        if (mif.HI !== ehi || mif.LO !== elo) begin
            bad++;
            $display("FAIL %s result got HI=%h LO=%h exp HI=%h LO=%h", name, mif.HI, mif.LO, ehi, elo);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        total++;
        if (mif.Busy !== 1'b0 || mif.HI !== 32'd0 || mif.LO !== 32'd0) begin
            bad++;
            $display("FAIL reset_state got Busy=%b HI=%h LO=%h exp 0/0/0", mif.Busy, mif.HI, mif.LO);
        end
        launch(3'b010, 32'd100, 32'd7);
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if (mif.Busy !== 1'b0 || mif.HI !== 32'd0 || mif.LO !== 32'd0) begin
            bad++;
            $display("FAIL reset_mid_run got Busy=%b HI=%h LO=%h exp 0/0/0", mif.Busy, mif.HI, mif.LO);
        end
        repeat (12) tick();
        total++;
        if (mif.Busy !== 1'b0 || mif.HI !== 32'd0 || mif.LO !== 32'd0) begin
            bad++;
            $display("FAIL reset_no_late_commit got Busy=%b HI=%h LO=%h exp 0/0/0", mif.Busy, mif.HI, mif.LO);
        end
    endtask

    task automatic test_mult();
        run_op("mult_neg5x3", 3'b000, 32'hFFFF_FFFB, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult_maxsq", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'h0000_0000, 32'h0000_0001);
    endtask

    task automatic test_div();
        run_op("div_m7_2", 3'b010, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_7_m2", 3'b010, 32'd7, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD);
        run_op("divu_7_0", 3'b011, 32'd7, 32'd0, 10, 32'h0000_0007, 32'hFFFF_FFFF);
        run_op("div_min_m1", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);
        run_op("divu_big", 3'b011, 32'hFFFF_FFF9, 32'd2, 10, 32'h0000_0001, 32'h7FFF_FFFC);
        run_op("div_m5_0", 3'b010, 32'hFFFF_FFFB, 32'd0, 10, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    endtask

    task automatic test_mthi_mtlo();
        mif.MDOp = 3'b100;
        mif.A    = 32'h0000_AAAA;
        tick();
        idle_inputs();
        total++;
        if (mif.HI !== 32'h0000_AAAA || mif.Busy !== 1'b0) begin
            bad++;
            $display("FAIL mthi got HI=%h Busy=%b exp HI=0000aaaa Busy=0", mif.HI, mif.Busy);
        end
        mif.MDOp = 3'b101;
        mif.A    = 32'h0000_5555;
        tick();
        idle_inputs();
        total++;
        if (mif.LO !== 32'h0000_5555 || mif.HI !== 32'h0000_AAAA) begin
            bad++;
            $display("FAIL mtlo got HI=%h LO=%h exp 0000aaaa/00005555", mif.HI, mif.LO);
        end
        // Start with a move opcode is ignored entirely.
        launch(3'b100, 32'h9999_9999, 32'd0);
        total++;
        if (mif.HI !== 32'h0000_AAAA || mif.Busy !== 1'b0) begin
            bad++;
            $display("FAIL start_mthi_ignored got HI=%h Busy=%b exp 0000aaaa/0", mif.HI, mif.Busy);
        end
    endtask

    task automatic test_flush();
        launch(3'b010, 32'd50, 32'd5);
        mif.Start = 1'b0;
        total++;
        if (mif.Busy !== 1'b1) begin
            bad++;
            $display("FAIL flush_setup got Busy=%b exp 1", mif.Busy);
        end
        repeat (12) tick();
        // Now HI=0 LO=10; a flushed launch must leave everything alone.
        mif.Start = 1'b1;
        mif.MDOp  = 3'b010;
        mif.A     = 32'd9;
        mif.B     = 32'd2;
        mif.Flush = 1'b1;
        tick();
        idle_inputs();
        total++;
        if (mif.Busy !== 1'b0) begin
            bad++;
            $display("FAIL flush_launch got Busy=%b exp 0", mif.Busy);
        end
        repeat (12) tick();
        total++;
        if (mif.HI !== 32'd0 || mif.LO !== 32'd10) begin
            bad++;
            $display("FAIL flush_launch_hilo got HI=%h LO=%h exp 0/a", mif.HI, mif.LO);
        end
        mif.MDOp  = 3'b100;
        mif.A     = 32'h0000_1234;
        mif.Flush = 1'b1;
        tick();
        idle_inputs();
        total++;
        if (mif.HI !== 32'd0) begin
            bad++;
            $display("FAIL flush_mthi got HI=%h exp 0", mif.HI);
        end
        // Flush during RUN does not abort the op.
        launch(3'b000, 32'd6, 32'd7);
        mif.Flush = 1'b1;
        tick();
        mif.Flush = 1'b0;
        repeat (6) tick();
        total++;
        if (mif.Busy !== 1'b0 || mif.LO !== 32'd42 || mif.HI !== 32'd0) begin
            bad++;
            $display("FAIL flush_in_run got Busy=%b HI=%h LO=%h exp 0/0/2a", mif.Busy, mif.HI, mif.LO);
        end
    endtask

    task automatic test_ignored_in_run();
        launch(3'b000, 32'd2, 32'd3);
        mif.MDOp = 3'b101;
        mif.A    = 32'hDEAD_BEEF;
        tick();
        mif.MDOp = 3'b100;
        tick();
        idle_inputs();
        repeat (3) tick();
        total++;
        if (mif.Busy !== 1'b0 || mif.LO !== 32'd6 || mif.HI !== 32'd0) begin
            bad++;
            $display("FAIL mtlo_in_run got Busy=%b HI=%h LO=%h exp 0/0/6", mif.Busy, mif.HI, mif.LO);
        end
    endtask

    task automatic test_back_to_back();
        // Start presented in the commit cycle (last Busy cycle) is dropped.
        launch(3'b001, 32'd10, 32'd11);
        repeat (4) tick();
        total++;
        if (mif.Busy !== 1'b1) begin
            bad++;
            $display("FAIL commit_cycle_busy got Busy=%b exp 1", mif.Busy);
        end
        mif.Start = 1'b1;
        mif.MDOp  = 3'b011;
        mif.A     = 32'd100;
        mif.B     = 32'd3;
        tick();
        idle_inputs();
        total++;
        if (mif.Busy !== 1'b0 || mif.LO !== 32'd110 || mif.HI !== 32'd0) begin
            bad++;
            $display("FAIL start_at_commit got Busy=%b HI=%h LO=%h exp 0/0/6e", mif.Busy, mif.HI, mif.LO);
        end
        // Immediate relaunch once Busy=0 is accepted.
        run_op("divu_relaunch", 3'b011, 32'd100, 32'd3, 10, 32'd1, 32'd33);
        run_op("mult_b2b", 3'b000, 32'h0001_0000, 32'h0001_0000, 5, 32'd1, 32'd0);
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        test_reset();
        test_mult();
        test_div();
        test_mthi_mtlo();
        test_flush();
        test_ignored_in_run();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
